debug_dump_controller: RTL and testbench

- Parametrised successor to the single-word debug controller.
- On a matching debug request it walks DEPTH consecutive source addresses (register file or data memory). Each word is read with a configurable read latency and sliced MSB-first into zero-padded NB_LATCH-bit frames.
- Frames go to the debug interface over a valid/ready handshake, so the interface can stall.
- Sits between the MIPS datapath read ports and the debug UART/frame interface; one instance per dumpable resource, distinguished by CONTROLLER_ID.

---
 rtl/debug_dump_controller.sv | 157 +++++++++++++++
 tb/tb_debug_dump_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_controller.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_controller
//  Description : On a rising-edge debug request, reads DEPTH consecutive
//                source words (register file or data memory), pads each word
//                with zeros at the LSB end, and streams it MSB-first as
//                NB_LATCH-bit frames over a valid/ready handshake.
//  Revision    : 1.0 - initial parametrised multi-word dump controller
// ============================================================================
module debug_dump_controller #(
    parameter int         NB_LATCH      = 32,
    parameter int         NB_INPUT_SIZE = 32,
    parameter int         NB_ADDR       = 5,
    parameter int         DEPTH         = 32,
    parameter int         RD_LATENCY    = 1,
    parameter logic [5:0] CONTROLLER_ID = 6'b100000
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [5:0]               i_request_select,
    input  logic [NB_INPUT_SIZE-1:0] i_data_from_mips,
    input  logic                     i_frame_ready,
    output logic [NB_ADDR-1:0]       o_addr,
    output logic [NB_LATCH-1:0]      o_frame_to_interface,
    output logic                     o_frame_valid,
    output logic                     o_busy,
    output logic                     o_done
);

    // Frames per word, padded word width and number of zero pad bits.
    localparam int c_F      = (NB_INPUT_SIZE + NB_LATCH - 1) / NB_LATCH;
    localparam int c_WORD_W = c_F * NB_LATCH;
    localparam int c_PAD    = c_WORD_W - NB_INPUT_SIZE;
    localparam int c_CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int c_IDX_W  = (c_F > 1) ? $clog2(c_F) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_READ = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_match;
    // Cleared by reset; keeps the first post-reset cycle from seeing a held
    // request as a fresh edge, since r_match has not yet sampled it.
    logic                r_primed;
    logic [NB_ADDR-1:0]  r_addr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_WORD_W-1:0] r_word;

    logic                w_match;
    logic                w_start;
    logic                w_lat_done;
    logic                w_xfer;
    logic                w_last_frame;
    logic                w_last_addr;
    logic [c_WORD_W-1:0] w_padded;

    assign w_match      = (i_request_select == CONTROLLER_ID);
    assign w_start      = w_match & ~r_match & r_primed;
    assign w_lat_done   = (r_cnt == c_CNT_W'(RD_LATENCY - 1));
    assign w_xfer       = (r_state == c_ST_SEND) & i_frame_ready;
    assign w_last_frame = (r_idx == c_IDX_W'(c_F - 1));
    assign w_last_addr  = (r_addr == NB_ADDR'(DEPTH - 1));
    // Source word left-justified in the frame grid, zeros below it.
    assign w_padded     = c_WORD_W'(i_data_from_mips) << c_PAD;

    // State register and request-edge history.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state  <= c_ST_IDLE;
            r_match  <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_match  <= w_match;
            r_primed <= 1'b1;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next_state  = r_state;
        o_busy        = 1'b0;
        o_frame_valid = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) w_next_state = c_ST_READ;
            end
            c_ST_READ: begin
                o_busy = 1'b1;
                if (!w_match)        w_next_state = c_ST_IDLE;
                else if (w_lat_done) w_next_state = c_ST_SEND;
            end
            c_ST_SEND: begin
                o_busy        = 1'b1;
                o_frame_valid = 1'b1;
                if (!w_match)
                    w_next_state = c_ST_IDLE;
                else if (w_xfer && w_last_frame)
                    w_next_state = w_last_addr ? c_ST_DONE : c_ST_READ;
            end
            c_ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Address walk, latency count and word/frame shifting.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_word <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_addr <= '0;
                        r_cnt  <= '0;
                    end
                end
                c_ST_READ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_lat_done) begin
                        r_word <= w_padded;
                        r_idx  <= '0;
                    end
                end
                c_ST_SEND: begin
                    if (w_xfer) begin
                        if (!w_last_frame) begin
                            // Next frame moves into the top slice.
                            r_idx  <= r_idx + 1'b1;
                            r_word <= r_word << NB_LATCH;
                        end else if (!w_last_addr) begin
                            r_addr <= r_addr + 1'b1;
                            r_cnt  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_addr               = r_addr;
    assign o_frame_to_interface = r_word[c_WORD_W-1 -: NB_LATCH];

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_dump_controller
//  Description : Directed self-checking bench for debug_dump_controller with
//                four parameterisations (basic/backpressure/abort, 40-bit
//                padded word, 64-bit word, 3-cycle latency full-depth walk).
//  Revision    : 1.0 - initial bench
// ============================================================================
module tb_debug_dump_controller;

    localparam logic [5:0] c_ID = 6'b100000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ready = 1'b1;
    logic [5:0] req_a = 6'd0, req_b = 6'd0, req_c = 6'd0, req_d = 6'd0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance A: 32-bit words, DEPTH 4, latency 1, mem[a] = 0xA0 + a.
    logic [4:0]  addr_a;
    logic [31:0] data_a, frame_a;
    logic        valid_a, busy_a, done_a;
    assign data_a = 32'hA0 + {27'd0, addr_a};

    debug_dump_controller #(.NB_LATCH(32), .NB_INPUT_SIZE(32), .NB_ADDR(5),
        .DEPTH(4), .RD_LATENCY(1), .CONTROLLER_ID(c_ID)) u_dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_request_select(req_a),
        .i_data_from_mips(data_a), .i_frame_ready(ready), .o_addr(addr_a),
        .o_frame_to_interface(frame_a), .o_frame_valid(valid_a),
        .o_busy(busy_a), .o_done(done_a));

    // Instance B: 40-bit word, one word.
    logic [4:0]  addr_b;
    logic [39:0] data_b;
    logic [31:0] frame_b;
    logic        valid_b, busy_b, done_b;
    assign data_b = 40'h123456789A;

    debug_dump_controller #(.NB_LATCH(32), .NB_INPUT_SIZE(40), .NB_ADDR(5),
        .DEPTH(1), .RD_LATENCY(1), .CONTROLLER_ID(c_ID)) u_dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_request_select(req_b),
        .i_data_from_mips(data_b), .i_frame_ready(ready), .o_addr(addr_b),
        .o_frame_to_interface(frame_b), .o_frame_valid(valid_b),
        .o_busy(busy_b), .o_done(done_b));

    // Instance C: 64-bit word, one word.
    logic [4:0]  addr_c;
    logic [63:0] data_c;
    logic [31:0] frame_c;
    logic        valid_c, busy_c, done_c;
    assign data_c = 64'h1122334455667788;

    debug_dump_controller #(.NB_LATCH(32), .NB_INPUT_SIZE(64), .NB_ADDR(5),
        .DEPTH(1), .RD_LATENCY(1), .CONTROLLER_ID(c_ID)) u_dut_c (
        .i_clock(clk), .i_reset(rst_n), .i_request_select(req_c),
        .i_data_from_mips(data_c), .i_frame_ready(ready), .o_addr(addr_c),
        .o_frame_to_interface(frame_c), .o_frame_valid(valid_c),
        .o_busy(busy_c), .o_done(done_c));

    // Instance D: latency 3, full 32-word walk; memory is a 2-stage
    // registered address pipe feeding mem[a] = 0xC0DE0000 + a.
    logic [4:0]  addr_d;
    logic [4:0]  d_pipe1 = 5'd0, d_pipe2 = 5'd0;
    logic [31:0] data_d, frame_d;
    logic        valid_d, busy_d, done_d;
    always @(posedge clk) begin
        d_pipe1 <= addr_d;
        d_pipe2 <= d_pipe1;
    end
    assign data_d = 32'hC0DE0000 + {27'd0, d_pipe2};

    debug_dump_controller #(.NB_LATCH(32), .NB_INPUT_SIZE(32), .NB_ADDR(5),
        .DEPTH(32), .RD_LATENCY(3), .CONTROLLER_ID(c_ID)) u_dut_d (
        .i_clock(clk), .i_reset(rst_n), .i_request_select(req_d),
        .i_data_from_mips(data_d), .i_frame_ready(ready), .o_addr(addr_d),
        .o_frame_to_interface(frame_d), .o_frame_valid(valid_d),
        .o_busy(busy_d), .o_done(done_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset held for 3 cycles with A's request already asserted.
        req_a = c_ID;
        repeat (3) tick();
        chk("rst_addr_a",  64'(addr_a),  64'd0);
        chk("rst_frame_a", 64'(frame_a), 64'd0);
        chk("rst_valid_a", 64'(valid_a), 64'd0);
        chk("rst_busy_a",  64'(busy_a),  64'd0);
        chk("rst_done_a",  64'(done_a),  64'd0);
        chk("rst_frame_b", 64'(frame_b), 64'd0);

        // Held request across reset release must not start a dump.
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy1", 64'(busy_a), 64'd0);
        tick();
        chk("post_rst_busy2", 64'(busy_a), 64'd0);
        chk("post_rst_valid", 64'(valid_a), 64'd0);

        // Re-assert: basic 4-word dump with ready high.
        req_a = 6'd0;
        tick();
        req_a = c_ID;
        tick();
        for (int a = 0; a < 4; a++) begin
            chk("basic_read_busy",  64'(busy_a),  64'd1);
            chk("basic_read_valid", 64'(valid_a), 64'd0);
            chk("basic_read_addr",  64'(addr_a),  64'(a));
            tick();
            chk("basic_send_valid", 64'(valid_a), 64'd1);
            chk("basic_send_frame", 64'(frame_a), 64'(32'hA0 + a));
            tick();
        end
        chk("basic_done",       64'(done_a),  64'd1);
        chk("basic_done_busy",  64'(busy_a),  64'd0);
        chk("basic_done_valid", 64'(valid_a), 64'd0);
        tick();
        chk("basic_done_pulse", 64'(done_a), 64'd0);
        tick();
        chk("level_no_restart", 64'(busy_a), 64'd0);

        // Backpressure on frame 1.
        req_a = 6'd0;
        tick();
        req_a = c_ID;
        tick();
        chk("bp_start_busy", 64'(busy_a), 64'd1);
        tick();
        chk("bp_frame0", 64'(frame_a), 64'hA0);
        tick();
        chk("bp_read1_valid", 64'(valid_a), 64'd0);
        tick();
        chk("bp_frame1", 64'(frame_a), 64'hA1);
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp_hold_valid", 64'(valid_a), 64'd1);
            chk("bp_hold_frame", 64'(frame_a), 64'hA1);
            chk("bp_hold_addr",  64'(addr_a),  64'd1);
        end
        ready = 1'b1;
        tick();
        chk("bp_resume_valid", 64'(valid_a), 64'd0);
        chk("bp_resume_addr",  64'(addr_a),  64'd2);
        tick();
        chk("bp_frame2_valid", 64'(valid_a), 64'd1);
        chk("bp_frame2",       64'(frame_a), 64'hA2);

        // Abort mid-SEND at address 2.
        req_a = 6'd0;
        ready = 1'b0;
        tick();
        chk("abort_busy",  64'(busy_a),  64'd0);
        chk("abort_valid", 64'(valid_a), 64'd0);
        chk("abort_done",  64'(done_a),  64'd0);
        tick();
        chk("abort_done2", 64'(done_a), 64'd0);
        ready = 1'b1;
        req_a = c_ID;
        tick();
        chk("rereq_busy", 64'(busy_a), 64'd1);
        chk("rereq_addr", 64'(addr_a), 64'd0);
        tick();
        chk("rereq_frame", 64'(frame_a), 64'hA0);
        req_a = 6'd0;
        tick();
        chk("rereq_abort_busy", 64'(busy_a), 64'd0);

        // 40-bit word: two frames, second zero-padded.
        req_b = c_ID;
        tick();
        chk("w40_busy", 64'(busy_b), 64'd1);
        tick();
        chk("w40_valid0", 64'(valid_b), 64'd1);
        chk("w40_frame0", 64'(frame_b), 64'h12345678);
        tick();
        chk("w40_valid1", 64'(valid_b), 64'd1);
        chk("w40_frame1", 64'(frame_b), 64'h9A000000);
        tick();
        chk("w40_done", 64'(done_b), 64'd1);
        tick();
        chk("w40_done_pulse", 64'(done_b), 64'd0);
        req_b = 6'd0;

        // 64-bit word: two frames, no padding.
        req_c = c_ID;
        tick();
        tick();
        chk("w64_frame0", 64'(frame_c), 64'h11223344);
        tick();
        chk("w64_frame1", 64'(frame_c), 64'h55667788);
        tick();
        chk("w64_done", 64'(done_c), 64'd1);
        chk("w64_busy", 64'(busy_c), 64'd0);
        tick();
        req_c = 6'd0;

        // Latency 3, full 32-word walk.
        req_d = c_ID;
        tick();
        for (int a = 0; a < 32; a++) begin
            for (int c = 0; c < 3; c++) begin
                chk("lat3_read_valid", 64'(valid_d), 64'd0);
                chk("lat3_read_addr",  64'(addr_d),  64'(a));
                tick();
            end
            chk("lat3_send_valid", 64'(valid_d), 64'd1);
            chk("lat3_send_frame", 64'(frame_d), 64'(32'hC0DE0000 + a));
            tick();
        end
        chk("lat3_done",      64'(done_d), 64'd1);
        chk("lat3_last_addr", 64'(addr_d), 64'd31);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("lat3_single_done", 64'(done_d), 64'd0);
            chk("lat3_idle_busy",   64'(busy_d), 64'd0);
            chk("lat3_no_wrap",     64'(addr_d), 64'd31);
        end
        req_d = 6'd0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
